control_unit: RTL and testbench

Multicycle sequencer for the RV32I datapath. Decodes the instruction register contents and walks a Moore FSM that drives every datapath select and enable, so that each instruction completes in 3–5 cycles. Sits beside the datapath inside the core top level: it consumes `instr` and `zero` and returns all control strobes.

---
 rtl/control_pkg.sv | 83 ++++++++
 rtl/control_unit_alu_decoder.sv | 44 ++++
 rtl/control_unit.sv | 198 +++++++++++++++++++
 tb/tb_control_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared constants for the RV32I multicycle control unit: FSM states, opcodes,
// ALU operation codes and datapath select encodings.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR1    = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLL    = 4'd6;
  localparam logic [3:0] ALU_SRL    = 4'd7;
  localparam logic [3:0] ALU_SRA    = 4'd8;
  localparam logic [3:0] ALU_SLTU   = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  // State classes seen by the ALU decoder.
  localparam logic [1:0] ALU_CLS_ADD    = 2'd0;
  localparam logic [1:0] ALU_CLS_EXEC   = 2'd1;
  localparam logic [1:0] ALU_CLS_BRANCH = 2'd2;
  localparam logic [1:0] ALU_CLS_PASS_B = 2'd3;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALU_OUT    = 2'd0;
  localparam logic [1:0] RES_MEM_DATA   = 2'd1;
  localparam logic [1:0] RES_ALU_RESULT = 2'd2;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_RS1    = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  // Branch decision from the compare result; SLT/SLTU yield zero when not less.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = !zero;
      3'b101:  branch_taken = zero;
      3'b110:  branch_taken = !zero;
      3'b111:  branch_taken = zero;
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_alu_decoder.sv
// Combinational ALU operation decoder: maps the current state class, funct3,
// funct7[5] and opcode to the ALU control code.
module alu_decoder
  import control_pkg::*;
(
  input  logic [1:0] alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic [6:0] opcode,
  output logic [3:0] alu_control
);

  logic is_rtype;
  assign is_rtype = (opcode == OP_OP);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      ALU_CLS_EXEC: begin
        case (funct3)
          // Immediate forms use bit 30 as immediate data except for SRAI.
          3'b000:  alu_control = (funct7_5 && is_rtype) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      ALU_CLS_BRANCH: begin
        case (funct3)
          3'b100, 3'b101: alu_control = ALU_SLT;
          3'b110, 3'b111: alu_control = ALU_SLTU;
          default:        alu_control = ALU_SUB;
        endcase
      end
      ALU_CLS_PASS_B: alu_control = ALU_PASS_B;
      default:        alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle RV32I sequencer: Moore FSM driving every datapath select/enable.
// Optional CONTROL_UNIT_ILLEGAL_HALT_EN: unknown opcodes halt and set illegal_instr.
module control_unit
  import control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         imm_src,
  output logic [3:0]         alu_control,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_dbg
);

`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
  localparam state_t ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [1:0] alu_class;
  logic [3:0] dec_alu_control;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7_5          = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign state_dbg         = STATE_W'(state_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
  logic illegal_q, illegal_d;
  logic opcode_known;

  always_comb begin
    case (opcode)
      OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_known = 1'b1;
      default:                           opcode_known = 1'b0;
    endcase
    illegal_d = illegal_q | ((state_q == S_DECODE) && !opcode_known);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= illegal_d;
  end

  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_OP:             state_d = S_EXECR;
          OP_OPIMM:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR1:    state_d = S_JALR2;
      S_JALR2:    state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_HALT:     state_d = ILLEGAL_NEXT;
      default:    state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .opcode      (opcode),
    .alu_control (dec_alu_control)
  );

  // Reset gates every strobe so a write in flight is dropped asynchronously.
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALU_OUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    imm_src     = IMM_I;
    alu_class   = ALU_CLS_ADD;
    alu_control = 4'd0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU_RESULT;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          if (opcode == OP_BRANCH)   imm_src = IMM_B;
          else if (opcode == OP_JAL) imm_src = IMM_J;
        end
        S_MEMADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: adr_src = 1'b1;
        S_MEMWB: begin
          result_src = RES_MEM_DATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = SRC_A_RS1;
          alu_class = ALU_CLS_EXEC;
        end
        S_EXECI: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_class = ALU_CLS_EXEC;
        end
        S_ALUWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = SRC_A_RS1;
          alu_class = ALU_CLS_BRANCH;
          pc_write  = branch_taken(funct3, zero);
        end
        S_JAL, S_JALR2: begin
          pc_write  = 1'b1;
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_FOUR;
        end
        S_JALR1: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
        end
        S_LUI: begin
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_U;
          alu_class = ALU_CLS_PASS_B;
        end
        S_AUIPC: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_U;
        end
        default: ;
      endcase
      alu_control = dec_alu_control;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, reset/illegal sequences and
// randomized instructions checked against a per-instruction step model.
module tb_control_unit;
  import control_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        zero = 1'b0;
  logic        pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control;
  logic        illegal_instr;
  logic [3:0]  state_dbg;

  always #5 clk = ~clk;

  control_unit #(.STATE_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .zero          (zero),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .alu_control   (alu_control),
    .illegal_instr (illegal_instr),
    .state_dbg     (state_dbg)
  );

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          step;
    out_t        exp;
  } vec_t;

  localparam int NV = 16;
  localparam logic [3:0] BASE_OP [8] = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
  localparam logic [2:0] BR_F3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  int          n_checks = 0;
  int          n_fail = 0;
  logic [18:0] exp_q[$];
  vec_t        vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", name, got, exp);
    end
  endtask

  function automatic out_t dut_out();
    return {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
            alu_src_a, alu_src_b, imm_src, alu_control, illegal_instr};
  endfunction

  function automatic out_t mk(input logic pw, input logic adr, input logic ir, input logic mw,
                              input logic rw, input logic [1:0] res, input logic [1:0] a,
                              input logic [1:0] b, input logic [2:0] imm, input logic [3:0] alu);
    return {pw, adr, ir, mw, rw, res, a, b, imm, alu, 1'b0};
  endfunction

  // Cycles per instruction including FETCH; unknown opcodes fall back after DECODE.
  function automatic int model_len(input logic [31:0] ins);
    case (ins[6:0])
      OP_LOAD, OP_JALR:                     return 5;
      OP_BRANCH:                            return 3;
      OP_STORE, OP_OP, OP_OPIMM, OP_JAL,
      OP_LUI, OP_AUIPC:                     return 4;
      default:                              return 2;
    endcase
  endfunction

  // Expected control outputs for cycle 'step' of instruction 'ins'.
  function automatic out_t model_step(input logic [31:0] ins, input int step, input logic z);
    out_t       o;
    logic [2:0] f3;
    logic [6:0] opc;
    o   = '0;
    f3  = ins[14:12];
    opc = ins[6:0];
    if (step == 0) return mk(1, 0, 1, 0, 0, 2, 0, 2, 0, 0);
    if (step == 1) return mk(0, 0, 0, 0, 0, 0, 1, 1, (opc == OP_BRANCH) ? 3'd2 : (opc == OP_JAL) ? 3'd3 : 3'd0, 0);
    case (opc)
      OP_LOAD: begin
        if (step == 2) o = mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        if (step == 3) o = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        if (step == 4) o = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      end
      OP_STORE: begin
        if (step == 2) o = mk(0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
        if (step == 3) o = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      end
      OP_OP: begin
        logic [3:0] op;
        op = BASE_OP[f3];
        if (ins[30] && f3 == 3'd0) op = 4'd1;
        if (ins[30] && f3 == 3'd5) op = 4'd8;
        if (step == 2) o = mk(0, 0, 0, 0, 0, 0, 2, 0, 0, op);
        if (step == 3) o = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      end
      OP_OPIMM: begin
        logic [3:0] op;
        op = BASE_OP[f3];
        if (ins[30] && f3 == 3'd5) op = 4'd8;
        if (step == 2) o = mk(0, 0, 0, 0, 0, 0, 2, 1, 0, op);
        if (step == 3) o = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      end
      OP_BRANCH: begin
        logic take;
        case (f3)
          3'd0, 3'd5, 3'd7: take = z;
          3'd1, 3'd4, 3'd6: take = !z;
          default:          take = 1'b0;
        endcase
        o = mk(take, 0, 0, 0, 0, 0, 2, 0, 0, (f3 < 3'd4) ? 4'd1 : (f3 < 3'd6) ? 4'd5 : 4'd9);
      end
      OP_JAL: begin
        if (step == 2) o = mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        if (step == 3) o = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      end
      OP_JALR: begin
        if (step == 2) o = mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0);
        if (step == 3) o = mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        if (step == 4) o = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      end
      OP_LUI: begin
        if (step == 2) o = mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 10);
        if (step == 3) o = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      end
      OP_AUIPC: begin
        if (step == 2) o = mk(0, 0, 0, 0, 0, 0, 1, 1, 4, 0);
        if (step == 3) o = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
    k = $urandom_range(0, 8);
`else
    k = $urandom_range(0, 9);
`endif
    case (k)
      0: r[6:0] = OP_LOAD;
      1: r[6:0] = OP_STORE;
      2: r[6:0] = OP_OP;
      3: r[6:0] = OP_OPIMM;
      4: begin
        r[6:0]   = OP_BRANCH;
        r[14:12] = BR_F3[$urandom_range(0, 5)];
      end
      5: r[6:0] = OP_JAL;
      6: r[6:0] = OP_JALR;
      7: r[6:0] = OP_LUI;
      8: r[6:0] = OP_AUIPC;
      default: r[6:0] = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0001111;
    endcase
    return r;
  endfunction

  // Runs one instruction from FETCH; the FETCH-cycle instr is junk on purpose.
  task automatic run_instr(input logic [31:0] ins, input bit zrand, input logic zfix,
                           input int chk_step, input out_t chk_exp, input string tag);
    int   len;
    logic z;
    logic zs[$];
    out_t got;
    len = model_len(ins);
    for (int s = 0; s < len; s++) begin
      z = zrand ? 1'($urandom_range(0, 1)) : zfix;
      zs.push_back(z);
      exp_q.push_back(model_step(ins, s, z));
    end
    for (int s = 0; s < len; s++) begin
      instr = (s == 0) ? $urandom : ins;
      zero  = zs.pop_front();
      #1;
      got = dut_out();
      check($sformatf("%s_step%0d", tag, s), got, exp_q.pop_front());
      if (s == chk_step) check(tag, got, chk_exp);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h00500093, 1'b0, 2, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 0)};
    vecs[1]  = '{32'h00500093, 1'b0, 3, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0)};
    vecs[2]  = '{32'h00500093, 1'b0, 0, mk(1, 0, 1, 0, 0, 2, 0, 2, 0, 0)};
    vecs[3]  = '{32'h0000A103, 1'b0, 3, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{32'h0000A103, 1'b0, 4, mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0)};
    vecs[5]  = '{32'h0020A023, 1'b0, 2, mk(0, 0, 0, 0, 0, 0, 2, 1, 1, 0)};
    vecs[6]  = '{32'h0020A023, 1'b0, 3, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0)};
    vecs[7]  = '{32'h00208463, 1'b1, 2, mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 1)};
    vecs[8]  = '{32'h00208463, 1'b0, 2, mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 1)};
    vecs[9]  = '{32'h00208463, 1'b0, 1, mk(0, 0, 0, 0, 0, 0, 1, 1, 2, 0)};
    vecs[10] = '{32'h40208133, 1'b0, 2, mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 1)};
    vecs[11] = '{32'h4020D113, 1'b0, 2, mk(0, 0, 0, 0, 0, 0, 2, 1, 0, 8)};
    vecs[12] = '{32'h008000EF, 1'b0, 2, mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0)};
    vecs[13] = '{32'h000080E7, 1'b0, 3, mk(1, 0, 0, 0, 0, 0, 1, 2, 0, 0)};
    vecs[14] = '{32'h123450B7, 1'b0, 2, mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 10)};
    vecs[15] = '{32'h00001097, 1'b0, 2, mk(0, 0, 0, 0, 0, 0, 1, 1, 4, 0)};

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_outputs", dut_out(), 32'd0);
    check("reset_state", state_dbg, 32'(S_FETCH));
    rst = 1'b1;

    for (int i = 0; i < NV; i++)
      run_instr(vecs[i].ins, 1'b0, vecs[i].z, vecs[i].step, vecs[i].exp, $sformatf("vec%0d", i));

    // Reset asserted during MEMWRITE
    for (int s = 0; s < 3; s++) begin
      instr = (s == 0) ? $urandom : 32'h0020A023;
      zero  = 1'b0;
      #1;
      check($sformatf("swrst_step%0d", s), dut_out(), model_step(32'h0020A023, s, 1'b0));
      @(posedge clk);
      @(negedge clk);
    end
    instr = 32'h0020A023;
    #1;
    check("swrst_memwrite", mem_write, 32'd1);
    rst = 1'b0;
    #1;
    check("swrst_async_clear", dut_out(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("swrst_held", dut_out(), 32'd0);
    rst = 1'b1;
    run_instr(32'h00500093, 1'b0, 1'b0, 0, mk(1, 0, 1, 0, 0, 2, 0, 2, 0, 0), "swrst_refetch");

    // Unknown opcode
`ifdef CONTROL_UNIT_ILLEGAL_HALT_EN
    for (int s = 0; s < 2; s++) begin
      instr = (s == 0) ? $urandom : 32'hFFFFFFFF;
      #1;
      check($sformatf("ill_step%0d", s), dut_out(), model_step(32'hFFFFFFFF, s, 1'b0));
      @(posedge clk);
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      instr = $urandom;
      #1;
      check($sformatf("halt_hold%0d", c), dut_out(), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("halt_reset_clear", dut_out(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
`else
    run_instr(32'hFFFFFFFF, 1'b0, 1'b0, -1, '0, "ill_nop");
`endif
    run_instr(32'h00500093, 1'b0, 1'b0, 0, mk(1, 0, 1, 0, 0, 2, 0, 2, 0, 0), "after_ill");

    // Randomized instruction stream
    for (int i = 0; i < 200; i++)
      run_instr(rand_instr(), 1'b1, 1'b0, -1, '0, $sformatf("rnd%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
